// File: rtl/mem_pkg.sv
// Shared memory-side definitions: byte-enable encodings
// and the commit-port FSM state type.
package mem_pkg;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_WAIT
  } mem_state_e;

endpackage

// File: rtl/store_align.sv
// Lane aligner for store commits: shifts strobes/data
// by the byte offset and flags accesses it cannot place.
module store_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  byte_en,
  input  logic [31:0] data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misaligned
);

  logic [6:0] strb7;

  // Shift into lanes; halfwords must also sit on an even byte.
  always_comb begin
    strb7      = {3'b000, byte_en} << addr_lo;
    wstrb      = strb7[3:0];
    wdata      = data << {addr_lo, 3'b000};
    misaligned = (|strb7[6:4])
               || ((byte_en == BE_HALF) && addr_lo[0]);
  end

endmodule

// File: rtl/store_commit_port.sv
// Commit-stream responder: one-entry write buffer,
// load/store bus arbitration and registered bus requests.
module store_commit_port
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            wr_byte_en,
  output logic                  wr_ready,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rd_resp_valid,
  output logic [DATA_WIDTH-1:0] rd_resp_data,
  output logic                  bus_req_valid,
  output logic                  bus_req_we,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic [DATA_WIDTH-1:0] bus_req_wdata,
  output logic [3:0]            bus_req_wstrb,
  input  logic                  bus_req_ready,
  input  logic                  bus_resp_valid,
  input  logic [DATA_WIDTH-1:0] bus_resp_rdata,
  output logic                  misalign_err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  idle
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = ADDR_WIDTH - 2;

  mem_state_e state_q, state_d;

  logic                  buf_valid_q, buf_valid_d;
  logic [WW-1:0]         buf_word_q, buf_word_d;
  logic [DATA_WIDTH-1:0] buf_wdata_q, buf_wdata_d;
  logic [3:0]            buf_wstrb_q, buf_wstrb_d;
  logic [CW-1:0]         starve_q, starve_d;

  logic                  breq_valid_q, breq_valid_d;
  logic                  breq_we_q, breq_we_d;
  logic [ADDR_WIDTH-1:0] breq_addr_q, breq_addr_d;
  logic [DATA_WIDTH-1:0] breq_wdata_q, breq_wdata_d;
  logic [3:0]            breq_wstrb_q, breq_wstrb_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic [3:0]            al_wstrb;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic                  al_mis;
  logic                  wr_accept;
  logic                  buf_hit;
  logic                  force_wr;
  logic                  unused_rd_lo;

  store_align u_align (
    .addr_lo    (wr_addr[1:0]),
    .byte_en    (wr_byte_en),
    .data       (wr_data),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .misaligned (al_mis)
  );

  assign unused_rd_lo = ^rd_addr[1:0];

  assign wr_ready  = !buf_valid_q;
  assign wr_accept = wr_valid && wr_ready;
  assign buf_hit   = rd_addr[ADDR_WIDTH-1:2] == buf_word_q;
  assign force_wr  = buf_valid_q
                   && ((starve_q == CW'(STARVE_LIMIT))
                   || (rd_valid && buf_hit));
  assign rd_ready  = !rst && (state_q == ST_IDLE)
                   && !force_wr;
  assign idle      = !buf_valid_q && (state_q == ST_IDLE);

  assign rd_resp_valid = rsp_valid_q;
  assign rd_resp_data  = rsp_data_q;
  assign bus_req_valid = breq_valid_q;
  assign bus_req_we    = breq_we_q;
  assign bus_req_addr  = breq_addr_q;
  assign bus_req_wdata = breq_wdata_q;
  assign bus_req_wstrb = breq_wstrb_q;
  assign misalign_err  = mis_q;
  assign err_addr      = err_addr_q;

  // Buffer fill, arbitration and bus request sequencing.
  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_word_d   = buf_word_q;
    buf_wdata_d  = buf_wdata_q;
    buf_wstrb_d  = buf_wstrb_q;
    starve_d     = starve_q;
    breq_valid_d = breq_valid_q;
    breq_we_d    = breq_we_q;
    breq_addr_d  = breq_addr_q;
    breq_wdata_d = breq_wdata_q;
    breq_wstrb_d = breq_wstrb_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    mis_d        = 1'b0;
    err_addr_d   = err_addr_q;

    if (wr_accept) begin
      if (al_mis) begin
        mis_d      = 1'b1;
        err_addr_d = wr_addr;
      end else if (wr_byte_en != 4'b0000) begin
        buf_valid_d = 1'b1;
        buf_word_d  = wr_addr[ADDR_WIDTH-1:2];
        buf_wdata_d = al_wdata;
        buf_wstrb_d = al_wstrb;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rd_valid && rd_ready) begin
          state_d      = ST_RD_ISSUE;
          breq_valid_d = 1'b1;
          breq_we_d    = 1'b0;
          breq_addr_d  = {rd_addr[ADDR_WIDTH-1:2], 2'b00};
          breq_wdata_d = '0;
          breq_wstrb_d = 4'b0000;
          if (buf_valid_q) begin
            starve_d = starve_q + CW'(1);
          end
        end else if (buf_valid_d) begin
          state_d      = ST_WR_ISSUE;
          breq_valid_d = 1'b1;
          breq_we_d    = 1'b1;
          breq_addr_d  = {buf_word_d, 2'b00};
          breq_wdata_d = buf_wdata_d;
          breq_wstrb_d = buf_wstrb_d;
        end
      end
      ST_WR_ISSUE: begin
        if (bus_req_ready) begin
          state_d      = ST_IDLE;
          breq_valid_d = 1'b0;
          buf_valid_d  = 1'b0;
          starve_d     = '0;
        end
      end
      ST_RD_ISSUE: begin
        if (bus_req_ready) begin
          state_d      = ST_RD_WAIT;
          breq_valid_d = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        if (bus_resp_valid) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus_resp_rdata;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      buf_valid_q  <= 1'b0;
      buf_word_q   <= '0;
      buf_wdata_q  <= '0;
      buf_wstrb_q  <= 4'b0000;
      starve_q     <= '0;
      breq_valid_q <= 1'b0;
      breq_we_q    <= 1'b0;
      breq_addr_q  <= '0;
      breq_wdata_q <= '0;
      breq_wstrb_q <= 4'b0000;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      mis_q        <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_word_q   <= buf_word_d;
      buf_wdata_q  <= buf_wdata_d;
      buf_wstrb_q  <= buf_wstrb_d;
      starve_q     <= starve_d;
      breq_valid_q <= breq_valid_d;
      breq_we_q    <= breq_we_d;
      breq_addr_q  <= breq_addr_d;
      breq_wdata_q <= breq_wdata_d;
      breq_wstrb_q <= breq_wstrb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      mis_q        <= mis_d;
      err_addr_q   <= err_addr_d;
    end
  end

endmodule
